// File: rtl/z_pipe_csa.sv
// Pipelined carry-select adder/subtractor: K stages of M bits with a global valid/ready advance.
// Optional build macro Z_PIPE_CSA_SAT_EN saturates the sum on signed overflow.
module z_pipe_csa #(
    parameter int K = 2,
    parameter int M = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [K*M-1:0]   a,
    input  logic [K*M-1:0]   b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [K*M-1:0]   sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int N = K * M;

    logic           en_s;
    logic [N-1:0]   b_eff_s;
    logic           cin_eff_s;

    logic           valid_r [K];
    logic [N-1:0]   sum_r   [K];
    logic           carry_r [K];
    logic [N-1:0]   a_r     [K];
    logic [N-1:0]   b_r     [K];
    logic           am_r    [K];
    logic           bm_r    [K];
    logic           ovf_r;

    logic [N-1:0]   a_i_s     [K];
    logic [N-1:0]   b_i_s     [K];
    logic [N-1:0]   sum_i_s   [K];
    logic [N-1:0]   sum_nx_s  [K];
    logic           cin_i_s   [K];
    logic           v_i_s     [K];
    logic           am_i_s    [K];
    logic           bm_i_s    [K];
    logic           carry_nx_s[K];
    logic [M:0]     s0_s      [K];
    logic [M:0]     s1_s      [K];
    logic [M:0]     sel_s     [K];
    logic           ovf_nx_s;
`ifdef Z_PIPE_CSA_SAT_EN
    logic [N-1:0]   sat_s;
`endif

    // Operand conditioning and the whole-pipe advance enable
    always_comb begin
        b_eff_s   = sub ? ~b : b;
        cin_eff_s = sub ? 1'b1 : c_in;
        en_s      = !valid_r[K-1] || out_ready;
    end

    assign in_ready  = en_s;
    assign out_valid = valid_r[K-1];
    assign sum       = sum_r[K-1];
    assign c_out     = carry_r[K-1];
    assign ovf       = ovf_r;

    // Per-stage block resolve: both carry hypotheses, picked by the previous stage's carry
    always_comb begin
        for (int j = 0; j < K; j++) begin
            if (j == 0) begin
                a_i_s[j]   = a;
                b_i_s[j]   = b_eff_s;
                sum_i_s[j] = {N{1'b0}};
                cin_i_s[j] = cin_eff_s;
                v_i_s[j]   = in_valid;
                am_i_s[j]  = a[N-1];
                bm_i_s[j]  = b_eff_s[N-1];
            end else begin
                a_i_s[j]   = a_r[(j > 0) ? j - 1 : 0];
                b_i_s[j]   = b_r[(j > 0) ? j - 1 : 0];
                sum_i_s[j] = sum_r[(j > 0) ? j - 1 : 0];
                cin_i_s[j] = carry_r[(j > 0) ? j - 1 : 0];
                v_i_s[j]   = valid_r[(j > 0) ? j - 1 : 0];
                am_i_s[j]  = am_r[(j > 0) ? j - 1 : 0];
                bm_i_s[j]  = bm_r[(j > 0) ? j - 1 : 0];
            end
            s0_s[j]  = {1'b0, a_i_s[j][j*M +: M]} + {1'b0, b_i_s[j][j*M +: M]};
            s1_s[j]  = {1'b0, a_i_s[j][j*M +: M]} + {1'b0, b_i_s[j][j*M +: M]} + {{M{1'b0}}, 1'b1};
            sel_s[j] = cin_i_s[j] ? s1_s[j] : s0_s[j];
            carry_nx_s[j] = sel_s[j][M];
            sum_nx_s[j]   = sum_i_s[j];
            sum_nx_s[j][j*M +: M] = sel_s[j][M-1:0];
        end
        // Overflow is resolved as the top block lands so the flag leaves a register
        ovf_nx_s = (am_i_s[K-1] == bm_i_s[K-1]) && (sum_nx_s[K-1][N-1] != am_i_s[K-1]);
`ifdef Z_PIPE_CSA_SAT_EN
        sat_s        = {N{1'b0}};
        sat_s[N-1]   = 1'b1;
        if (!am_i_s[K-1]) begin
            sat_s = ~sat_s;
        end else begin
            sat_s = sat_s;
        end
        if (ovf_nx_s) begin
            sum_nx_s[K-1] = sat_s;
        end else begin
            sum_nx_s[K-1] = sum_nx_s[K-1];
        end
`endif
    end

    // Pipeline registers: the whole pipe shifts on en and holds otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < K; j++) begin
                valid_r[j] <= 1'b0;
                sum_r[j]   <= {N{1'b0}};
                carry_r[j] <= 1'b0;
                a_r[j]     <= {N{1'b0}};
                b_r[j]     <= {N{1'b0}};
                am_r[j]    <= 1'b0;
                bm_r[j]    <= 1'b0;
            end
            ovf_r <= 1'b0;
        end else if (en_s) begin
            for (int j = 0; j < K; j++) begin
                valid_r[j] <= v_i_s[j];
                sum_r[j]   <= sum_nx_s[j];
                carry_r[j] <= carry_nx_s[j];
                a_r[j]     <= a_i_s[j];
                b_r[j]     <= b_i_s[j];
                am_r[j]    <= am_i_s[j];
                bm_r[j]    <= bm_i_s[j];
            end
            ovf_r <= ovf_nx_s;
        end
    end
endmodule

// File: tb/tb_z_pipe_csa.sv
// Self-checking bench for z_pipe_csa (K=2, M=4): directed vectors plus a queue-based arithmetic model.
module tb_z_pipe_csa;
    logic       clk, rst, in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out, ovf;
    logic [7:0] a, b, sum;

    int n_pass  = 0;
    int n_total = 0;
    logic [9:0] exp_q[$];
    logic [9:0] e_v;

`ifdef Z_PIPE_CSA_SAT_EN
    localparam logic [7:0] OVF_SUM = 8'h7F;
`else
    localparam logic [7:0] OVF_SUM = 8'h80;
`endif

    z_pipe_csa #(.K(2), .M(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Arithmetic reference: returns {ovf, c_out, sum}
    function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                         input logic mc, input logic ms);
        int ua, ub, sa, sb, tot, stot;
        logic [7:0] s;
        logic co, ov;
        ua = int'(ma);
        ub = int'(mb);
        sa = ma[7] ? ua - 256 : ua;
        sb = mb[7] ? ub - 256 : ub;
        if (ms) begin
            tot  = ua - ub;
            co   = (ua >= ub);
            stot = sa - sb;
        end else begin
            tot  = ua + ub + int'(mc);
            co   = (tot >= 256);
            stot = sa + sb + int'(mc);
        end
        s  = 8'(tot & 255);
        ov = (stot > 127) || (stot < -128);
`ifdef Z_PIPE_CSA_SAT_EN
        if (ov) s = ma[7] ? 8'h80 : 8'h7F;
`endif
        return {ov, co, s};
    endfunction

    // Cycle-by-cycle comparison of the DUT against the model queue
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e_v = exp_q[0];
                    check("sum", 32'(sum), 32'(e_v[7:0]));
                    check("c_out", 32'(c_out), 32'(e_v[8]));
                    check("ovf", 32'(ovf), 32'(e_v[9]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, c_in, sub));
        end
    end

    task automatic run_one(input string nm, input logic [7:0] va, input logic [7:0] vb,
                           input logic vc, input logic vs,
                           input logic [7:0] es, input logic ec, input logic eo);
        @(posedge clk); #1;
        in_valid = 1'b1; a = va; b = vb; c_in = vc; sub = vs;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({nm, "_early"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({nm, "_valid"}, 32'(out_valid), 32'd1);
        check({nm, "_sum"}, 32'(sum), 32'(es));
        check({nm, "_cout"}, 32'(c_out), 32'(ec));
        check({nm, "_ovf"}, 32'(ovf), 32'(eo));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int idx, stall_cnt, ocnt, acc, cyc;
        logic [7:0] got[$];
        logic ivp[12];
        logic ovp[12];

        rst = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'h00);
        check("rst_c_out", 32'(c_out), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        run_one("add_basic", 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0);
        run_one("add_carry", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run_one("sub_borrow", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_one("add_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, OVF_SUM, 1'b0, 1'b1);
        run_one("sub_cin_ignored", 8'h09, 8'h03, 1'b1, 1'b1, 8'h06, 1'b1, 1'b0);

        // Back-pressure: four adds, downstream stalls for cycles 3..5
        idx = 0; stall_cnt = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            in_valid = (idx < 4);
            a = 8'h10 + 8'(idx); b = 8'h00; c_in = 1'b0; sub = 1'b0;
            out_ready = !(c >= 3 && c <= 5);
            @(negedge clk);
            if (!in_ready) stall_cnt++;
            if (out_valid && out_ready) got.push_back(sum);
            if (in_valid && in_ready) idx++;
        end
        check("bp_stall_cycles", 32'(stall_cnt), 32'd3);
        check("bp_count", 32'(got.size()), 32'd4);
        for (int k = 0; k < got.size(); k++)
            check($sformatf("bp_item%0d", k), 32'(got[k]), 32'h10 + 32'(k));

        // Bubbles: alternating in_valid must reappear two cycles later
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            in_valid = (c < 8) && (c % 2 == 0);
            a = 8'(c); b = 8'(3 * c); out_ready = 1'b1;
            @(negedge clk);
            ivp[c] = in_valid;
            ovp[c] = out_valid;
        end
        check("bubble_c0", 32'(ovp[0]), 32'd0);
        check("bubble_c1", 32'(ovp[1]), 32'd0);
        for (int c = 2; c < 12; c++)
            check($sformatf("bubble_c%0d", c), 32'(ovp[c]), 32'(ivp[c-2]));

        // Reset with two items in flight
        @(posedge clk); #1;
        in_valid = 1'b1; a = 8'h21; b = 8'h01; out_ready = 1'b0;
        @(posedge clk); #1;
        a = 8'h22;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("rst_inflight_held", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("rst_discard_next", 32'(out_valid), 32'd0);
        ocnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) ocnt++;
        end
        check("rst_never_appear", 32'(ocnt), 32'd0);

        // Random sweep with random back-pressure
        acc = 0; cyc = 0;
        while (acc < 10000 && cyc < 40000) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 9) < 8);
            a         = 8'($urandom);
            b         = 8'($urandom);
            c_in      = 1'($urandom);
            sub       = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            cyc++;
        end
        check("rand_accepted", 32'(acc), 32'd10000);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_out_valid", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
